// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: one outstanding write and one outstanding read,
// with independent channels. Register contents are exported flat on reg_out,
// and each committed write raises a one-cycle reg_wr pulse.
module axi_lite_reg_slave #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic [2:0]                 AWPROT,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [DATA_W/8-1:0]        WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic [2:0]                 ARPROT,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [DATA_W*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]        reg_wr
);

  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Captured address/data beats waiting for their partner
  logic              aw_held;
  logic              w_held;
  logic [IDX_W-1:0]  aw_idx;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;

  logic              aw_hs_c;
  logic              w_hs_c;
  logic              ar_hs_c;
  logic              commit_c;
  logic              wr_hit_c;
  logic [IDX_W-1:0]  wr_idx_c;
  logic [DATA_W-1:0] wr_data_c;
  logic [STRB_W-1:0] wr_strb_c;
  logic              rd_hit_c;
  logic [DATA_W-1:0] rd_word_c;
  logic              unused_c;

  // Byte lanes below the word index and the protection bits carry no meaning here
  assign unused_c = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  // Readiness depends only on registered state (and reset), never on VALID
  assign AWREADY = ARESETN && !aw_held && !BVALID;
  assign WREADY  = ARESETN && !w_held  && !BVALID;
  assign ARREADY = ARESETN && !RVALID;

  // Write decode: merge a live handshake with any previously held beat
  always_comb begin
    aw_hs_c   = AWVALID && AWREADY;
    w_hs_c    = WVALID && WREADY;
    wr_idx_c  = aw_held ? aw_idx : AWADDR[ADDR_W-1:2];
    wr_data_c = w_held ? w_data : WDATA;
    wr_strb_c = w_held ? w_strb : WSTRB;
    commit_c  = (aw_held || aw_hs_c) && (w_held || w_hs_c);
    wr_hit_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_idx_c == IDX_W'(i)) wr_hit_c = 1'b1;
    end
  end

  // Read decode: select the addressed register, zero when out of range
  always_comb begin
    ar_hs_c   = ARVALID && ARREADY;
    rd_hit_c  = 1'b0;
    rd_word_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ARADDR[ADDR_W-1:2] == IDX_W'(i)) begin
        rd_hit_c  = 1'b1;
        rd_word_c = reg_out[DATA_W*i +: DATA_W];
      end
    end
  end

  // Write channel: beat capture, commit into the register bank, B response
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      BVALID  <= 1'b0;
      BRESP   <= RESP_OKAY;
      reg_wr  <= '0;
      reg_out <= '0;
    end else begin
      reg_wr <= '0;
      if (commit_c) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        BVALID  <= 1'b1;
        BRESP   <= wr_hit_c ? RESP_OKAY : RESP_SLVERR;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (wr_idx_c == IDX_W'(i)) begin
            reg_wr[i] <= 1'b1;
            for (int unsigned b = 0; b < STRB_W; b++) begin
              if (wr_strb_c[b]) reg_out[DATA_W*i + 8*b +: 8] <= wr_data_c[8*b +: 8];
            end
          end
        end
      end else begin
        if (aw_hs_c) begin
          aw_held <= 1'b1;
          aw_idx  <= AWADDR[ADDR_W-1:2];
        end
        if (w_hs_c) begin
          w_held <= 1'b1;
          w_data <= WDATA;
          w_strb <= WSTRB;
        end
      end
      // No commit can coincide with an open response, since both READYs are low then
      if (BVALID && BREADY) BVALID <= 1'b0;
    end
  end

  // Read channel: one-cycle data return held until the R handshake
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else if (ar_hs_c) begin
      RVALID <= 1'b1;
      RDATA  <= rd_word_c;
      RRESP  <= rd_hit_c ? RESP_OKAY : RESP_SLVERR;
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed and randomized checks of the AXI4-Lite register bank against a
// word-array reference model.
module tb_axi_lite_reg_slave;

  logic         ACLK;
  logic         ARESETN;
  logic [5:0]   AWADDR;
  logic [2:0]   AWPROT;
  logic         AWVALID;
  logic         AWREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         WVALID;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic [5:0]   ARADDR;
  logic [2:0]   ARPROT;
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: four 32-bit words
  logic [31:0] mdl [4];

  axi_lite_reg_slave #(.DATA_W(32), .ADDR_W(6), .NUM_REGS(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_out(reg_out), .reg_wr(reg_wr)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mdl_flat();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  function automatic bit in_range(input logic [5:0] addr);
    return int'(addr[5:2]) < 4;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [5:0] addr);
    return in_range(addr) ? mdl[addr[5:2]] : 32'h0;
  endfunction

  // Apply a write to the model; returns the expected response code
  task automatic model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [3:0] wr);
    logic [31:0] w;
    resp = 2'b10;
    wr   = 4'b0;
    if (in_range(addr)) begin
      w = mdl[addr[5:2]];
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      mdl[addr[5:2]] = w;
      resp = 2'b00;
      wr   = 4'(1 << addr[5:2]);
    end
  endtask

  // Complete an open B response and confirm the channel reopens
  task automatic b_complete(input string tag);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check({tag, " bvalid_clear"}, BVALID, 1'b0);
    check({tag, " wr_pulse_end"}, reg_wr, 4'b0);
    check({tag, " awready_back"}, AWREADY, 1'b1);
    check({tag, " wready_back"}, WREADY, 1'b1);
  endtask

  // lead = 0: AW and W together; lead > 0: W first by lead cycles; lead < 0: AW first
  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input string tag);
    logic [1:0] eresp;
    logic [3:0] ewr;
    int n;
    n = (lead < 0) ? -lead : lead;
    BREADY = 1'b0;
    if (lead == 0) begin
      AWADDR = addr; WDATA = data; WSTRB = strb;
      AWVALID = 1'b1; WVALID = 1'b1;
      check({tag, " awready"}, AWREADY, 1'b1);
      check({tag, " wready"}, WREADY, 1'b1);
      tick();
    end else begin
      if (lead > 0) begin
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        check({tag, " wready"}, WREADY, 1'b1);
      end else begin
        AWADDR = addr; AWVALID = 1'b1;
        check({tag, " awready"}, AWREADY, 1'b1);
      end
      tick();
      // Keep the leading VALID up with a corrupted payload: it must not be re-captured
      if (lead > 0) WDATA = ~data; else AWADDR = addr ^ 6'h3C;
      for (int k = 0; k < n; k++) begin
        check({tag, " early_bvalid"}, BVALID, 1'b0);
        if (lead > 0) check({tag, " wready_held"}, WREADY, 1'b0);
        else check({tag, " awready_held"}, AWREADY, 1'b0);
        if (k < n - 1) tick();
      end
      if (lead > 0) begin
        AWADDR = addr; AWVALID = 1'b1;
        check({tag, " awready"}, AWREADY, 1'b1);
      end else begin
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        check({tag, " wready"}, WREADY, 1'b1);
      end
      tick();
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    model_write(addr, data, strb, eresp, ewr);
    check({tag, " bvalid"}, BVALID, 1'b1);
    check({tag, " bresp"}, BRESP, eresp);
    check({tag, " reg_wr"}, reg_wr, ewr);
    check({tag, " reg_out"}, reg_out, mdl_flat());
    b_complete(tag);
  endtask

  task automatic do_read(input logic [5:0] addr, input int stall, input string tag);
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0;
    check({tag, " arready"}, ARREADY, 1'b1);
    tick();
    ARVALID = 1'b0;
    for (int k = 0; k <= stall; k++) begin
      check({tag, " rvalid"}, RVALID, 1'b1);
      check({tag, " rdata"}, RDATA, exp_rdata(addr));
      check({tag, " rresp"}, RRESP, in_range(addr) ? 2'b00 : 2'b10);
      check({tag, " arready_low"}, ARREADY, 1'b0);
      if (k < stall) tick();
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check({tag, " rvalid_clear"}, RVALID, 1'b0);
  endtask

  initial begin
    logic [31:0] d1, d2, old;
    logic [5:0]  a;
    logic [1:0]  eresp;
    logic [3:0]  ewr;

    ARESETN = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;

    // Reset state
    tick(); tick();
    check("rst awready", AWREADY, 1'b0);
    check("rst wready", WREADY, 1'b0);
    check("rst arready", ARREADY, 1'b0);
    check("rst bvalid", BVALID, 1'b0);
    check("rst rvalid", RVALID, 1'b0);
    check("rst rdata", RDATA, 32'h0);
    check("rst resp", {BRESP, RRESP}, 4'h0);
    check("rst reg_out", reg_out, 128'h0);
    check("rst reg_wr", reg_wr, 4'h0);
    ARESETN = 1'b1;
    tick();
    check("post_rst readies", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Fill all four registers, then read back
    for (int i = 0; i < 4; i++) do_write(6'(4 * i), 32'(i + 1), 4'hF, 0, "fill");
    for (int i = 0; i < 4; i++) do_read(6'(4 * i), 0, "fill_rd");
    check("fill literal", reg_out, 128'h00000004_00000003_00000002_00000001);

    // Partial strobe write
    do_write(6'h00, 32'hAABBCCDD, 4'b0101, 0, "strb");
    check("strb literal", reg_out[31:0], 32'h00BB00DD);
    do_read(6'h00, 1, "strb_rd");

    // W leads AW by 3 cycles, then AW leads W by 3 cycles, same payload
    d1 = $urandom;
    do_write(6'h08, d1, 4'hF, 3, "w_first");
    check("w_first value", reg_out[95:64], d1);
    do_write(6'h08, 32'h0, 4'hF, 0, "clear8");
    do_write(6'h08, d1, 4'hF, -3, "aw_first");
    check("aw_first value", reg_out[95:64], d1);

    // Out-of-range access and zero-strobe write
    do_write(6'h10, 32'hDEADBEEF, 4'hF, 0, "oor_wr");
    do_read(6'h10, 0, "oor_rd");
    do_write(6'h0C, 32'hFFFFFFFF, 4'h0, 0, "zero_strb");

    // B stalled for 5 cycles while a second write is offered
    d1 = $urandom; d2 = $urandom;
    AWADDR = 6'h0C; WDATA = d1; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    model_write(6'h0C, d1, 4'hF, eresp, ewr);
    check("stall first bvalid", BVALID, 1'b1);
    AWADDR = 6'h04; WDATA = d2; WSTRB = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall bvalid", BVALID, 1'b1);
      check("stall bresp", BRESP, 2'b00);
      check("stall readies", {AWREADY, WREADY}, 2'b00);
      check("stall reg_out", reg_out, mdl_flat());
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("stall b_done", BVALID, 1'b0);
    check("stall readies_back", {AWREADY, WREADY}, 2'b11);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    model_write(6'h04, d2, 4'hF, eresp, ewr);
    check("second bvalid", BVALID, 1'b1);
    check("second reg_wr", reg_wr, ewr);
    check("second reg_out", reg_out, mdl_flat());
    b_complete("second");

    // Same-edge write commit and read of 0x04
    do_write(6'h04, 32'h2, 4'hF, 0, "pre_same");
    old = mdl[1];
    AWADDR = 6'h04; WDATA = 32'h9; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 6'h04; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    model_write(6'h04, 32'h9, 4'hF, eresp, ewr);
    check("same rvalid", RVALID, 1'b1);
    check("same old_data", RDATA, old);
    check("same literal_old", RDATA, 32'h2);
    check("same bvalid", BVALID, 1'b1);
    check("same reg_out", reg_out, mdl_flat());
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    check("same both_clear", {BVALID, RVALID}, 2'b00);
    do_read(6'h04, 0, "same_next");
    check("same new_literal", reg_out[63:32], 32'h9);

    // Reset in the middle of a read, with a W beat held
    ARADDR = 6'h00; ARVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    ARVALID = 1'b0; WVALID = 1'b0;
    check("midrst rvalid_pre", RVALID, 1'b1);
    check("midrst w_held_pre", WREADY, 1'b0);
    ARESETN = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    check("midrst rvalid", RVALID, 1'b0);
    check("midrst bvalid", BVALID, 1'b0);
    check("midrst readies", {AWREADY, WREADY, ARREADY}, 3'b000);
    check("midrst reg_out", reg_out, 128'h0);
    ARESETN = 1'b1;
    tick();
    check("midrst readies_back", {AWREADY, WREADY, ARREADY}, 3'b111);
    for (int i = 0; i < 4; i++) do_read(6'(4 * i), 0, "midrst_rd");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      a = {4'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
      do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3, "rnd_wr");
      a = {4'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
      do_read(a, $urandom_range(0, 2), "rnd_rd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite responder that exposes a small bank of 32-bit read/write control registers to the PS or AXI master, including the VIP master used in block-design benches. It sits behind the interconnect inside the SLAM IP and drives the register contents as flat outputs to user logic. It also emits a one-cycle write pulse per register. Only one write and one read are outstanding at a time; the read and write channels operate independently.

Parameters:
DATA_W, 32, AXI data width (fixed at 32; other values unsupported)
ADDR_W, 6, AXI address width in bits
NUM_REGS, 4, number of registers, 1..2^(ADDR_W-2)

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
AWADDR  in  ADDR_W  write address
AWPROT  in  3  ignored
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WSTRB  in  4  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_W  read address
ARPROT  in  3  ignored
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
reg_out  out  32*NUM_REGS  register contents; reg i occupies bits [32i+31:32i]
reg_wr  out  NUM_REGS  one-cycle pulse per register on commit

Behaviour:
- Reset (ARESETN=0 sampled at the ACLK edge): all registers 0, reg_wr=0, BVALID=0, RVALID=0, RDATA=0, BRESP=RRESP=0, aw/w capture flags cleared. All READY outputs are 0 while ARESETN=0.
- Ready signals:
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - ARREADY = !RVALID.
  - All are combinational from registered state; none depend on a VALID input.
- Write capture:
  - The AW and W handshakes may occur in either order or in the same cycle.
  - A handshaked address or data beat is latched, with its flag set, until commit.
- Write commit:
  - Occurs at the edge that completes the later of the two handshakes, or both handshakes if simultaneous.
  - At that edge: BVALID goes to 1, both flags clear, and BRESP is set.
  - Word index = addr[ADDR_W-1:2]; addr[1:0] is ignored.
  - If index < NUM_REGS: bytes whose WSTRB bit is 1 are updated, BRESP=OKAY (00), and reg_wr[index]=1 for exactly one cycle.
  - Otherwise: no register changes, reg_wr stays 0, BRESP=SLVERR (10).
  - Latency: AW and W handshaked at edge N -> reg_out updated and BVALID=1 in cycle N+1.
- Write response:
  - BVALID holds, with BRESP stable, until BVALID&&BREADY.
  - It clears at that edge; AWREADY and WREADY return to 1 the following cycle.
  - A further AW or W cannot be accepted while BVALID=1.
- Read:
  - At the ARVALID&&ARREADY edge, RDATA is loaded with the register value and RRESP=OKAY, or with RDATA=0 and RRESP=SLVERR when out of range. RVALID goes to 1 at the same edge (one cycle latency).
  - RDATA, RRESP and RVALID hold until RVALID&&RREADY; RVALID clears at that edge.
  - Back-to-back reads therefore take at least 2 cycles each.
- Simultaneous read and write to the same register: a read accepted on the same edge as a write commit returns the OLD value. A read accepted on any later edge returns the new value.
- WSTRB=0000 to a valid address: no data change, BRESP=OKAY, reg_wr still pulses.
- Reset asserted mid-transaction: all flags and VALIDs drop on the reset edge and registers clear. No response is issued for the aborted transfer.
- AXI rule: VALID outputs never deassert without their handshake.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C (WSTRB=F), then read all four back -> RDATA 0x1..0x4, every BRESP and RRESP = 00, reg_out matches after each write.
- Write 0xAABBCCDD with WSTRB=0101 to 0x00 while the register holds 0x00000001 -> readback 0x00BB00DD; reg_wr[0] high for exactly 1 cycle.
- Present WVALID 3 cycles before AWVALID, then repeat with AW first -> each beat is accepted once; BVALID rises the cycle after the later handshake; register updated identically in both orders.
- Write and read to 0x10 (NUM_REGS=4) -> BRESP=10, RRESP=10, RDATA=0, no reg_out change, no reg_wr pulse.
- Hold BREADY=0 for 5 cycles after a write and offer a second AW/W -> BVALID and BRESP stable, AWREADY=WREADY=0 throughout; the second write is accepted only after the B handshake.
- Same-cycle write commit and read of 0x04 (old value 0x2, new value 0x9) -> that read returns 0x2, the next read returns 0x9. Then assert ARESETN=0 mid-read -> RVALID=0 and all registers read 0 afterwards.
